// File: rtl/shift_controller.sv
// Purpose : gearbox shift sequencer; qualifies rpm/pedal thresholds over a dwell window, then steps one gear and holds a clutch interval.
// Latency : shift lands DWELL_CYCLES+1 edges after the condition first appears (DWELL/4 for a braked downshift); clutch lasts SHIFT_CYCLES cycles.
// Backpressure: none; inputs are sampled every cycle and ignored while a shift is in progress.
module shift_controller #(
   parameter int unsigned UPSHIFT_RPM   = 6000,
   parameter int unsigned DOWNSHIFT_RPM = 2000,
   parameter int unsigned DWELL_CYCLES  = 25_000_000,
   parameter int unsigned SHIFT_CYCLES  = 5_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rpm,
   input  logic [1:0]  pedals,
   output logic [3:0]  gears,
   output logic        shifting
);

   // Thresholds as 32-bit unsigned so rpm above 2^31 never wraps negative.
   localparam logic [31:0] UP_TH   = 32'(UPSHIFT_RPM);
   localparam logic [31:0] DOWN_TH = 32'(DOWNSHIFT_RPM);

   // Terminal counter values; a zero-length window still takes one cycle.
   localparam int unsigned BRAKE_DWELL = (DWELL_CYCLES / 4 < 1) ? 1 : DWELL_CYCLES / 4;
   localparam logic [31:0] DWELL_LAST  = (DWELL_CYCLES == 0) ? 32'd0 : 32'(DWELL_CYCLES - 1);
   localparam logic [31:0] BRAKE_LAST  = 32'(BRAKE_DWELL - 1);
   localparam logic [31:0] SHIFT_LAST  = (SHIFT_CYCLES == 0) ? 32'd0 : 32'(SHIFT_CYCLES - 1);

   typedef enum logic [1:0] {
      IN_GEAR   = 2'd0,
      QUAL_UP   = 2'd1,
      QUAL_DOWN = 2'd2,
      SHIFTING  = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] cnt_q;
   logic [3:0]  gears_q;
   logic        shifting_q;

   logic        accel;
   logic        brake;
   logic        up_cond;
   logic        down_cond;
   logic [31:0] down_last;

   // Pedals are active-low; pressing both counts as brake only.
   assign brake     = ~pedals[1];
   assign accel     = ~pedals[0] & ~brake;
   assign up_cond   = (rpm >= UP_TH) && accel && (gears_q != 4'b1000);
   assign down_cond = (rpm <= DOWN_TH) && (gears_q != 4'b0001);
   // Braking shortens the downshift qualification window to a quarter.
   assign down_last = brake ? BRAKE_LAST : DWELL_LAST;

   assign gears    = gears_q;
   assign shifting = shifting_q;

   // Shift sequencer: qualify, step one gear on entry to SHIFTING, time the clutch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IN_GEAR;
         cnt_q      <= 32'd0;
         gears_q    <= 4'b0001;
         shifting_q <= 1'b0;
      end else begin
         case (state_q)
            IN_GEAR: begin
               cnt_q <= 32'd0;
               if (up_cond) begin
                  state_q <= QUAL_UP;
               end else if (down_cond) begin
                  state_q <= QUAL_DOWN;
               end
            end
            QUAL_UP: begin
               if (!up_cond) begin
                  state_q <= IN_GEAR;
                  cnt_q   <= 32'd0;
               end else if (cnt_q >= DWELL_LAST) begin
                  state_q    <= SHIFTING;
                  cnt_q      <= 32'd0;
                  gears_q    <= {gears_q[2:0], 1'b0};
                  shifting_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            QUAL_DOWN: begin
               if (up_cond) begin
                  // Upshift wins a tie; restart qualification from scratch.
                  state_q <= QUAL_UP;
                  cnt_q   <= 32'd0;
               end else if (!down_cond) begin
                  state_q <= IN_GEAR;
                  cnt_q   <= 32'd0;
               end else if (cnt_q >= down_last) begin
                  state_q    <= SHIFTING;
                  cnt_q      <= 32'd0;
                  gears_q    <= {1'b0, gears_q[3:1]};
                  shifting_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            SHIFTING: begin
               if (cnt_q >= SHIFT_LAST) begin
                  state_q    <= IN_GEAR;
                  cnt_q      <= 32'd0;
                  shifting_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 32'd1;
               end
            end
            default: begin
               state_q    <= IN_GEAR;
               cnt_q      <= 32'd0;
               gears_q    <= 4'b0001;
               shifting_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_controller.sv
module tb_shift_controller;

   logic        clk;
   logic        reset;
   logic [31:0] rpm;
   logic [1:0]  pedals;
   logic [3:0]  gears;
   logic        shifting;

   int errors = 0;
   int checks = 0;

   shift_controller #(
      .UPSHIFT_RPM  (6000),
      .DOWNSHIFT_RPM(2000),
      .DWELL_CYCLES (4),
      .SHIFT_CYCLES (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rpm     (rpm),
      .pedals  (pedals),
      .gears   (gears),
      .shifting(shifting)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] rpm;
      logic [1:0]  ped;
      logic [3:0]  g;
      logic        s;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [31:0] rp, input logic [1:0] p,
                      input logic [3:0] g, input logic s, input int n);
      vec_t v;
      v.rst = r; v.rpm = rp; v.ped = p; v.g = g; v.s = s;
      for (int k = 0; k < n; k++) tbl.push_back(v);
   endtask

   // Apply inputs, take one rising edge, settle 1 time unit past the edge.
   task automatic step(input logic r, input logic [31:0] rp, input logic [1:0] p);
      reset  = r;
      rpm    = rp;
      pedals = p;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [3:0] g, input logic s);
      checks++;
      if (gears !== g || shifting !== s) begin
         errors++;
         $display("FAIL %s: got gears=%b shifting=%b, expected gears=%b shifting=%b",
                  name, gears, shifting, g, s);
      end
   endtask

   task automatic run(input string name, input logic r, input logic [31:0] rp,
                      input logic [1:0] p, input logic [3:0] g, input logic s, input int n);
      for (int k = 0; k < n; k++) begin
         step(r, rp, p);
         chk($sformatf("%s[%0d]", name, k), g, s);
      end
   endtask

   initial begin
      reset = 1'b1; rpm = 32'd0; pedals = 2'b11;

      // Reset, then idle at rpm 0
      add(1, 0, 2'b11, 4'b0001, 0, 2);
      add(0, 0, 2'b11, 4'b0001, 0, 3);
      // Held upshift 1->2, then held on into 2->3
      add(0, 6000, 2'b10, 4'b0001, 0, 4);
      add(0, 6000, 2'b10, 4'b0010, 1, 3);
      add(0, 6000, 2'b10, 4'b0010, 0, 5);
      add(0, 6000, 2'b10, 4'b0100, 1, 3);
      add(0, 6000, 2'b10, 4'b0100, 0, 1);
      // Braked downshift 3->2 after one qualifying cycle; inputs ignored while shifting
      add(0, 1500, 2'b01, 4'b0100, 0, 1);
      add(0, 1500, 2'b01, 4'b0010, 1, 1);
      add(0, 3000, 2'b11, 4'b0010, 1, 2);
      add(0, 3000, 2'b11, 4'b0010, 0, 1);
      // Accel released at dwell count 2 restarts qualification
      add(0, 7000, 2'b10, 4'b0010, 0, 3);
      add(0, 7000, 2'b11, 4'b0010, 0, 1);
      add(0, 7000, 2'b10, 4'b0010, 0, 4);
      add(0, 7000, 2'b10, 4'b0100, 1, 1);
      add(0, 3000, 2'b11, 4'b0100, 1, 2);
      add(0, 3000, 2'b11, 4'b0100, 0, 1);
      // Unbraked downshift 3->2 needs the full 4-cycle dwell
      add(0, 1500, 2'b11, 4'b0100, 0, 4);
      add(0, 1500, 2'b11, 4'b0010, 1, 1);
      add(0, 3000, 2'b11, 4'b0010, 1, 2);
      add(0, 3000, 2'b11, 4'b0010, 0, 1);
      // Just-outside thresholds and huge unsigned rpm never qualify
      add(0, 5999, 2'b10, 4'b0010, 0, 6);
      add(0, 2001, 2'b11, 4'b0010, 0, 6);
      add(0, 2001, 2'b01, 4'b0010, 0, 3);
      add(0, 32'hFFFF_FFF0, 2'b01, 4'b0010, 0, 4);
      add(0, 32'h8000_0000, 2'b11, 4'b0010, 0, 4);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].rpm, tbl[i].ped);
         chk($sformatf("vec%0d", i), tbl[i].g, tbl[i].s);
      end

      // Gear 1 at rpm 0, and high rpm with both pedals (brake only): no shift
      run("g1_rpm0_rst", 1, 0, 2'b11, 4'b0001, 0, 2);
      run("g1_rpm0", 0, 0, 2'b11, 4'b0001, 0, 8);
      run("both_pedals", 0, 9000, 2'b00, 4'b0001, 0, 8);

      // Climb to 4th with accel held, then stay in 4th at 9000
      run("climb12_q", 0, 9000, 2'b10, 4'b0001, 0, 4);
      run("climb12_s", 0, 9000, 2'b10, 4'b0010, 1, 3);
      run("climb23_q", 0, 9000, 2'b10, 4'b0010, 0, 5);
      run("climb23_s", 0, 9000, 2'b10, 4'b0100, 1, 3);
      run("climb34_q", 0, 9000, 2'b10, 4'b0100, 0, 5);
      run("climb34_s", 0, 9000, 2'b10, 4'b1000, 1, 3);
      run("g4_hold", 0, 9000, 2'b10, 4'b1000, 0, 10);

      // Reset during the 2nd SHIFTING cycle abandons the shift at 1st gear
      run("rst_pre", 1, 0, 2'b11, 4'b0001, 0, 1);
      run("mid_q", 0, 6000, 2'b10, 4'b0001, 0, 4);
      run("mid_s", 0, 6000, 2'b10, 4'b0010, 1, 1);
      run("mid_rst", 1, 6000, 2'b10, 4'b0001, 0, 1);
      run("post_q", 0, 6000, 2'b10, 4'b0001, 0, 4);
      run("post_s", 0, 6000, 2'b10, 4'b0010, 1, 3);
      run("post_done", 0, 3000, 2'b11, 4'b0010, 0, 2);

      // DWELL/4 braked path from 2nd down to 1st, then gear-1 floor holds
      run("brk21_q", 0, 100, 2'b01, 4'b0010, 0, 1);
      run("brk21_s", 0, 100, 2'b01, 4'b0001, 1, 3);
      run("g1_floor", 0, 100, 2'b01, 4'b0001, 0, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
